// File: rtl/decoder_pkg.sv
// Shared widths, FIFO depth and sweep FSM state encodings for the 3-to-8 decoder slice.
package decoder_pkg;

   localparam int unsigned CODE_W     = 3;
   localparam int unsigned WORD_W     = 8;
   localparam int unsigned FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      SW_IDLE = 2'd0,
      SW_EMIT = 2'd1,
      SW_GAP  = 2'd2
   } sweep_state_e;

endpackage

// File: rtl/decoder3_8_seq_decode.sv
// Combinational 3-to-8 one-hot decoder; all-zero word when disabled.
module decoder3_8
   import decoder_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   input  logic              en_i,
   output logic [WORD_W-1:0] word_o
);

   always_comb begin
      word_o = '0;
      for (int unsigned k = 0; k < WORD_W; k++) begin
         if (en_i && (code_i == k[CODE_W-1:0])) begin
            word_o[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decoder3_8_seq.sv
// Decoder with a 2-entry output FIFO of decoded words and valid/ready handshakes.
// Optional self-test code sweep is enabled with the DECODER_SWEEP_EN macro.
module decoder3_8_seq
   import decoder_pkg::*;
#(
   parameter int unsigned SWEEP_GAP = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] code,
   input  logic              en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] y
`ifdef DECODER_SWEEP_EN
   ,
   input  logic              sweep_start,
   output logic              sweep_busy
`endif
);

   if (SWEEP_GAP > 15) begin : g_gap_range
      $error("decoder3_8_seq: SWEEP_GAP must be in 0..15");
   end

   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;
   logic              full;
   logic              empty;
   logic              busy;
   logic              host_push;
   logic              sweep_push;
   logic              push;
   logic              pop;
   logic [CODE_W-1:0] dec_code;
   logic              dec_en;
   logic [WORD_W-1:0] dec_word;

   assign full  = (count_q == 2'(FIFO_DEPTH));
   assign empty = (count_q == 2'd0);

`ifdef DECODER_SWEEP_EN
   sweep_state_e      state_q, state_d;
   logic [CODE_W-1:0] sw_code_q, sw_code_d;
   logic [3:0]        gap_q, gap_d;

   assign busy       = (state_q != SW_IDLE);
   assign sweep_push = (state_q == SW_EMIT) && !full;
   assign sweep_busy = busy;
   assign dec_code   = busy ? sw_code_q : code;
   assign dec_en     = busy ? 1'b1 : en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SW_IDLE;
         sw_code_q <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         sw_code_q <= sw_code_d;
         gap_q     <= gap_d;
      end
   end

   // The code counter advances when leaving EMIT directly (no gap) or when the gap expires.
   always_comb begin
      state_d   = state_q;
      sw_code_d = sw_code_q;
      gap_d     = gap_q;
      unique case (state_q)
         SW_IDLE: begin
            if (sweep_start) begin
               state_d   = SW_EMIT;
               sw_code_d = '0;
            end
         end
         SW_EMIT: begin
            if (!full) begin
               if (sw_code_q == '1) begin
                  state_d = SW_IDLE;
               end else if (SWEEP_GAP > 0) begin
                  state_d = SW_GAP;
                  gap_d   = '0;
               end else begin
                  sw_code_d = sw_code_q + 3'd1;
               end
            end
         end
         SW_GAP: begin
            if (gap_q == 4'(SWEEP_GAP - 1)) begin
               state_d   = SW_EMIT;
               sw_code_d = sw_code_q + 3'd1;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: state_d = SW_IDLE;
      endcase
   end
`else
   assign busy       = 1'b0;
   assign sweep_push = 1'b0;
   assign dec_code   = code;
   assign dec_en     = en;
`endif

   decoder3_8 u_dec (
      .code_i (dec_code),
      .en_i   (dec_en),
      .word_o (dec_word)
   );

   assign in_ready  = !full && !busy;
   assign host_push = in_valid && in_ready;
   assign push      = host_push || sweep_push;
   assign pop       = !empty && out_ready;
   assign out_valid = !empty;
   assign y         = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (push && !pop) begin
            count_q <= count_q + 2'd1;
         end else if (pop && !push) begin
            count_q <= count_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dec_word;
      end
   end

endmodule

// File: tb/tb_decoder3_8_seq.sv
// Self-checking bench for decoder3_8_seq: directed cases plus randomized traffic vs a queue model.
module tb_decoder3_8_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] code;
   logic       en;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
`ifdef DECODER_SWEEP_EN
   logic       sweep_start;
   logic       sweep_busy;
`endif

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [7:0]  model_q [$];

   always #5 clk = ~clk;

   decoder3_8_seq #(.SWEEP_GAP(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .code        (code),
      .en          (en),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .y           (y)
`ifdef DECODER_SWEEP_EN
      ,
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [7:0] exp_y;
      exp_y = (model_q.size() > 0) ? model_q[0] : 8'h00;
      check_eq({tag, "_in_ready"}, 32'(in_ready), 32'(model_q.size() < 2));
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(model_q.size() > 0));
      check_eq({tag, "_y"}, 32'(y), 32'(exp_y));
   endtask

   // Entered at a falling edge: drive, advance one rising edge, update model, check at next falling edge.
   task automatic step(input string tag, input logic r, input logic iv, input logic [2:0] c,
                       input logic e, input logic ordy);
      bit acc;
      bit rel;
      rst       = r;
      in_valid  = iv;
      code      = c;
      en        = e;
      out_ready = ordy;
      acc = iv && (model_q.size() < 2);
      rel = ordy && (model_q.size() > 0);
      @(posedge clk);
      if (r) begin
         model_q.delete();
      end else begin
         if (rel) void'(model_q.pop_front());
         if (acc) model_q.push_back(e ? 8'(1 << c) : 8'h00);
      end
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; code = '0; en = 1'b0; out_ready = 1'b0;
`ifdef DECODER_SWEEP_EN
      sweep_start = 1'b0;
`endif
      @(negedge clk);
      step("reset", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      check_eq("reset_in_ready", 32'(in_ready), 32'd1);
      check_eq("reset_y", 32'(y), 32'h00);

      step("basic", 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
      check_eq("basic_y", 32'(y), 32'h08);
      step("basic_drain", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      check_eq("basic_drain_valid", 32'(out_valid), 32'd0);

      step("fill0", 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
      step("fill6", 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
      check_eq("full_in_ready", 32'(in_ready), 32'd0);
      step("refuse7", 1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
      check_eq("full_head", 32'(y), 32'h01);
      step("rel0", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      check_eq("full_second", 32'(y), 32'h40);
      step("rel6", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      check_eq("full_empty", 32'(out_valid), 32'd0);

      step("en0", 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
      check_eq("en0_valid", 32'(out_valid), 32'd1);
      check_eq("en0_y", 32'(y), 32'h00);
      step("en0_rel", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

      step("hold1", 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
      step("swap", 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
      check_eq("swap_y", 32'(y), 32'h04);
      step("swap_rel", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

      step("two_a", 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
      step("two_b", 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
      step("mid_rst", 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
      step("post_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

      for (int i = 0; i < 400; i++) begin
         step("rand",
              1'($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 2) != 0));
      end

`ifdef DECODER_SWEEP_EN
      step("sw_rst", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sweep_start = 1'b1;
      @(posedge clk);
      sweep_start = 1'b0;
      @(negedge clk);
      check_eq("sweep_busy_start", 32'(sweep_busy), 32'd1);
      check_eq("sweep_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("sweep_y", 32'(y), 32'(8'(1 << i)));
         check_eq("sweep_valid", 32'(out_valid), 32'd1);
         if (i < 7) begin
            check_eq("sweep_busy", 32'(sweep_busy), 32'd1);
            check_eq("sweep_ready", 32'(in_ready), 32'd0);
         end
      end
      step("sw_end", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
